mmio_master_bridge: RTL and testbench

MMIO_MASTER_BRIDGE -- requirements
Module: mmio_master_bridge

---
 rtl/mmio_master_bridge.sv | 173 +++++++++++++++++
 tb/tb_mmio_master_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_master_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mmio_master_bridge
//  Description : Single-outstanding core-to-MMIO bridge. Decodes one 4 KiB page
//                per slave starting at 0x8000_0000, drives a shared MMIO bus
//                with per-slave valid/ready, and returns a one-cycle response
//                carrying load data or a decode/timeout error.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_master_bridge #(
    parameter int ADDR_W         = 13,
    parameter int PERIPH_NUM     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    input  logic [3:0]               req_wstrb,
    output logic                     resp_valid,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic [PERIPH_NUM-1:0]    mmio_valid,
    output logic                     mmio_we,
    output logic [ADDR_W-1:0]        mmio_addr,
    output logic [31:0]              mmio_wdata,
    output logic [3:0]               mmio_wstrb,
    input  logic [PERIPH_NUM-1:0]    mmio_ready,
    input  logic [32*PERIPH_NUM-1:0] mmio_rdata,
    input  logic [PERIPH_NUM-1:0]    irq_i,
    output logic [PERIPH_NUM-1:0]    irq_pending
);

    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_ACCESS = 2'd1;
    localparam logic [1:0]  c_ST_RESP   = 2'd2;

    localparam logic [19:0] c_PAGE_BASE = 20'h80000;
    localparam logic [15:0] c_TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_req_ready;
    logic [PERIPH_NUM-1:0] r_sel;
    logic [PERIPH_NUM-1:0] w_dec_sel;
    logic                  w_dec_hit;
    logic [19:0]           w_page_off;
    logic                  w_handshake;
    logic                  w_sel_ready;
    logic [31:0]           w_sel_rdata;
    logic                  w_timeout;
    logic [15:0]           r_tmo_cnt;
    logic                  r_mmio_we;
    logic [ADDR_W-1:0]     r_mmio_addr;
    logic [31:0]           r_mmio_wdata;
    logic [3:0]            r_mmio_wstrb;
    logic [31:0]           r_resp_rdata;
    logic                  r_resp_err;
    logic [PERIPH_NUM-1:0] r_irq_pending;

    assign w_page_off  = req_addr[31:12] - c_PAGE_BASE;
    assign w_handshake = req_valid & r_req_ready;
    assign w_sel_ready = |(mmio_ready & r_sel);
    assign w_timeout   = (r_tmo_cnt == c_TMO_LAST);

    // Target is held one-hot so the return path is a plain AND-OR mux.
    always_comb begin
        w_dec_sel   = '0;
        w_sel_rdata = '0;
        for (int i = 0; i < PERIPH_NUM; i++) begin
            if (w_page_off == 20'(i)) begin
                w_dec_sel[i] = 1'b1;
            end
            if (r_sel[i]) begin
                w_sel_rdata = w_sel_rdata | mmio_rdata[i*32 +: 32];
            end
        end
        w_dec_hit = |w_dec_sel;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_handshake) begin
                    w_state_nxt = w_dec_hit ? c_ST_ACCESS : c_ST_RESP;
                end
            end
            c_ST_ACCESS: begin
                if (w_sel_ready || w_timeout) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP:   w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready  <= 1'b0;
            r_sel        <= '0;
            r_tmo_cnt    <= '0;
            r_mmio_we    <= 1'b0;
            r_mmio_addr  <= '0;
            r_mmio_wdata <= '0;
            r_mmio_wstrb <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            // Registered so that ready is low while reset is held.
            r_req_ready <= (w_state_nxt == c_ST_IDLE);

            if (w_handshake) begin
                r_mmio_we    <= req_we;
                r_mmio_addr  <= req_addr[ADDR_W-1:0];
                r_mmio_wdata <= req_wdata;
                r_mmio_wstrb <= req_wstrb;
                r_sel        <= w_dec_sel;
                r_tmo_cnt    <= '0;
                if (!w_dec_hit) begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b1;
                end
            end

            if (r_state == c_ST_ACCESS) begin
                if (w_sel_ready) begin
                    r_resp_rdata <= r_mmio_we ? 32'd0 : w_sel_rdata;
                    r_resp_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b1;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_pending <= '0;
        end else begin
            r_irq_pending <= irq_i;
        end
    end

    assign req_ready   = r_req_ready;
    assign mmio_valid  = (r_state == c_ST_ACCESS) ? r_sel : '0;
    assign mmio_we     = r_mmio_we;
    assign mmio_addr   = r_mmio_addr;
    assign mmio_wdata  = r_mmio_wdata;
    assign mmio_wstrb  = r_mmio_wstrb;
    assign resp_valid  = (r_state == c_ST_RESP);
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign irq_pending = r_irq_pending;

endmodule
`default_nettype wire

// File: tb/tb_mmio_master_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_master_bridge
//  Description : Directed bench for mmio_master_bridge; responses are checked
//                against a queue of expected results by a separate monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_master_bridge;

    localparam int ADDR_W = 13;
    localparam int PN     = 2;
    localparam int TMO    = 8;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [PN-1:0]     mmio_valid;
    logic              mmio_we;
    logic [ADDR_W-1:0] mmio_addr;
    logic [31:0]       mmio_wdata;
    logic [3:0]        mmio_wstrb;
    logic [PN-1:0]     mmio_ready;
    logic [32*PN-1:0]  mmio_rdata;
    logic [PN-1:0]     irq_i;
    logic [PN-1:0]     irq_pending;

    mmio_master_bridge #(
        .ADDR_W         (ADDR_W),
        .PERIPH_NUM     (PN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mmio_valid  (mmio_valid),
        .mmio_we     (mmio_we),
        .mmio_addr   (mmio_addr),
        .mmio_wdata  (mmio_wdata),
        .mmio_wstrb  (mmio_wstrb),
        .mmio_ready  (mmio_ready),
        .mmio_rdata  (mmio_rdata),
        .irq_i       (irq_i),
        .irq_pending (irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every resp_valid cycle consumes one expected entry.
    always @(negedge clk) begin
        resp_t e;
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b, required no response (t=%0t)",
                         resp_rdata, resp_err, $time);
            end else begin
                e = exp_q.pop_front();
                chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
                chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
            end
        end
    end

    // Starts and ends just after a falling edge. slave<0 means unmapped.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int slave, input int stall,
                          input logic [31:0] rd, input logic [ADDR_W-1:0] exp_addr,
                          input int exp_vcyc, input logic [31:0] exp_rdata, input logic exp_err);
        int        vcyc = 0;
        int        lat  = 0;
        logic      got  = 1'b0;
        logic [1:0] oh;
        resp_t     e;
        oh = (slave >= 0) ? (2'b01 << slave) : 2'b00;
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        exp_q.push_back(e);
        if (slave >= 0) mmio_rdata[slave*32 +: 32] = rd;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = ~wdata;
        req_wstrb = ~wstrb;
        lat = 1;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (mmio_valid != '0) begin
                vcyc++;
                chk("mmio_valid", {62'd0, mmio_valid}, {62'd0, oh});
                chk("mmio_addr", {51'd0, mmio_addr}, {51'd0, exp_addr});
                chk("mmio_we", {63'd0, mmio_we}, {63'd0, we});
                chk("mmio_wdata", {32'd0, mmio_wdata}, {32'd0, wdata});
                chk("mmio_wstrb", {60'd0, mmio_wstrb}, {60'd0, wstrb});
                if (slave >= 0 && vcyc == stall + 1) mmio_ready[slave] = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        chk("resp_seen", {63'd0, got}, 64'd1);
        chk("valid_cycles", 64'(vcyc), 64'(exp_vcyc));
        chk("latency", 64'(lat), 64'(exp_vcyc + 1));
        chk("req_ready_in_resp", {63'd0, req_ready}, 64'd0);
        if (slave >= 0) mmio_ready[slave] = 1'b0;
        @(negedge clk);
        chk("resp_hold_rdata", {32'd0, resp_rdata}, {32'd0, exp_rdata});
        chk("resp_hold_err", {63'd0, resp_err}, {63'd0, exp_err});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        mmio_ready = '0;
        mmio_rdata = {32'hDEAD_BEEF, 32'hCAFE_F00D};
        irq_i      = 2'b11;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_mmio_valid", {62'd0, mmio_valid}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
        chk("rst_mmio_we", {63'd0, mmio_we}, 64'd0);
        chk("rst_mmio_addr", {51'd0, mmio_addr}, 64'd0);
        chk("rst_mmio_wdata", {32'd0, mmio_wdata}, 64'd0);
        chk("rst_mmio_wstrb", {60'd0, mmio_wstrb}, 64'd0);
        chk("rst_irq_pending", {62'd0, irq_pending}, 64'd0);
        irq_i = 2'b00;
        rst   = 1'b0;
        @(negedge clk);

        // SPI load, ready on first access cycle
        access(1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, 0, 32'h0000_00A5, 13'h004, 1, 32'h0000_00A5, 1'b0);
        // UART store, ready held low for 5 cycles
        access(1'b1, 32'h8000_100C, 32'h0000_0364, 4'hF, 1, 5, 32'h1234_5678, 13'h100C, 6, 32'h0, 1'b0);
        // Unmapped loads, including the page just past UART
        access(1'b0, 32'h0000_2000, 32'h0, 4'h0, -1, 0, 32'h0, 13'h0, 0, 32'h0, 1'b1);
        access(1'b0, 32'h8000_2000, 32'h0, 4'h0, -1, 0, 32'h0, 13'h0, 0, 32'h0, 1'b1);
        // UART load at the top of its page
        access(1'b0, 32'h8000_1FFC, 32'h0, 4'h0, 1, 2, 32'h0BAD_F00D, 13'h1FFC, 3, 32'h0BAD_F00D, 1'b0);
        // SPI timeout while the unselected UART port shows ready
        mmio_ready[1] = 1'b1;
        access(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1000, 32'h55AA_55AA, 13'h000, TMO, 32'h0, 1'b1);
        mmio_ready[1] = 1'b0;

        // Reset on the 3rd cycle of a stalled UART access
        chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h8000_1010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_valid_c1", {62'd0, mmio_valid}, 64'd2);
        @(negedge clk);
        @(negedge clk);
        chk("abort_valid_c3", {62'd0, mmio_valid}, 64'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid_off", {62'd0, mmio_valid}, 64'd0);
        chk("abort_ready_in_rst", {63'd0, req_ready}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", {63'd0, req_ready}, 64'd1);
        access(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, 0, 32'h00C0_FFEE, 13'h010, 1, 32'h00C0_FFEE, 1'b0);

        // IRQ pulse during an active UART store
        fork
            access(1'b1, 32'h8000_1004, 32'h0000_A5A5, 4'h3, 1, 3, 32'h7777_7777, 13'h1004, 4, 32'h0, 1'b0);
            begin
                @(negedge clk);
                chk("irq_before", {62'd0, irq_pending}, 64'd0);
                irq_i = 2'b10;
                @(negedge clk);
                chk("irq_pending_set", {62'd0, irq_pending}, 64'd2);
                irq_i = 2'b00;
                @(negedge clk);
                chk("irq_pending_clr", {62'd0, irq_pending}, 64'd0);
            end
        join

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
